rp_scope_calib_mc: RTL

RP_SCOPE_CALIB_MC -- requirements
Module: rp_scope_calib_mc

---
 rtl/rp_scope_calib_mc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rp_scope_calib_mc.sv
// Multi-channel scope calibration: offset add, unsigned gain, and saturation tracking.
// Optional saturation counters are built only when SCOPE_CALIB_SATCNT_EN is defined.
module rp_scope_calib_mc #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DBITS = 16,
  parameter int unsigned GBITS = 16,
  parameter int unsigned GFRAC = 15,
  parameter int unsigned SCW   = 16
) (
  input  logic                   adc_clk_i,
  input  logic                   adc_rstn_i,
  input  logic [NCH*DBITS-1:0]   calib_dat_i,
  input  logic                   calib_din_tvalid_i,
  output logic [NCH*DBITS-1:0]   calib_dat_o,
  output logic                   calib_dout_tvalid_o,
  input  logic [NCH*DBITS-1:0]   cfg_calib_offset_i,
  input  logic [NCH*GBITS-1:0]   cfg_calib_gain_i,
  input  logic                   cfg_update_i,
  output logic                   cfg_update_ack_o,
  input  logic                   sat_cnt_clr_i,
  output logic [NCH-1:0]         sat_flag_o,
  output logic [NCH*SCW-1:0]     sat_cnt_o
);

  localparam int unsigned SW = DBITS + 1;
  localparam int unsigned PW = DBITS + GBITS + 1;

  localparam logic signed [DBITS-1:0] DMAX   = {1'b0, {(DBITS-1){1'b1}}};
  localparam logic signed [DBITS-1:0] DMIN   = {1'b1, {(DBITS-1){1'b0}}};
  localparam logic signed [PW-1:0]    PMAX   = PW'(DMAX);
  localparam logic signed [PW-1:0]    PMIN   = PW'(DMIN);
  localparam logic [GBITS-1:0]        GUNITY = GBITS'(1) << GFRAC;

  // active coefficient set
  logic signed [DBITS-1:0] act_off  [NCH];
  logic        [GBITS-1:0] act_gain [NCH];

  // pipeline registers; coefficients travel with the sample from stage 1
  logic signed [DBITS-1:0] s1_dat  [NCH];
  logic signed [DBITS-1:0] s1_off  [NCH];
  logic        [GBITS-1:0] s1_gain [NCH];
  logic                    s1_vld;
  logic signed [DBITS-1:0] s2_dat  [NCH];
  logic        [GBITS-1:0] s2_gain [NCH];
  logic        [NCH-1:0]   s2_sat;
  logic                    s2_vld;
  logic signed [PW-1:0]    s3_prod [NCH];
  logic        [NCH-1:0]   s3_sat;
  logic                    s3_vld;

  // combinational stage results
  logic signed [SW-1:0]    sum_c   [NCH];
  logic signed [DBITS-1:0] clp2_c  [NCH];
  logic        [NCH-1:0]   sat2_c;
  logic signed [PW-1:0]    prod_c  [NCH];
  logic signed [PW-1:0]    shf_c   [NCH];
  logic signed [DBITS-1:0] clp4_c  [NCH];
  logic        [NCH-1:0]   sat4_c;
  logic        [NCH-1:0]   sat_ev_c;

  // offset add with clamp: overflow shows as a mismatch of the top two sum bits
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sum_c[k]  = SW'(s1_dat[k]) + SW'(s1_off[k]);
      sat2_c[k] = sum_c[k][SW-1] != sum_c[k][SW-2];
      if (sat2_c[k]) clp2_c[k] = sum_c[k][SW-1] ? DMIN : DMAX;
      else           clp2_c[k] = DBITS'(sum_c[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      prod_c[k] = PW'(s2_dat[k]) * PW'($signed({1'b0, s2_gain[k]}));
    end
  end

  // floor shift by GFRAC, then clamp back to sample range
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      shf_c[k] = s3_prod[k] >>> GFRAC;
      sat4_c[k] = 1'b0;
      if (shf_c[k] > PMAX) begin
        clp4_c[k] = DMAX;
        sat4_c[k] = 1'b1;
      end else if (shf_c[k] < PMIN) begin
        clp4_c[k] = DMIN;
        sat4_c[k] = 1'b1;
      end else begin
        clp4_c[k] = DBITS'(shf_c[k]);
      end
    end
  end

  always_comb begin
    sat_ev_c = {NCH{s3_vld}} & (s3_sat | sat4_c);
  end

  // coefficient load and acknowledge
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      for (int k = 0; k < NCH; k++) begin
        act_off[k]  <= '0;
        act_gain[k] <= GUNITY;
      end
      cfg_update_ack_o <= 1'b0;
    end else begin
      if (cfg_update_i) begin
        for (int k = 0; k < NCH; k++) begin
          act_off[k]  <= cfg_calib_offset_i[k*DBITS +: DBITS];
          act_gain[k] <= cfg_calib_gain_i[k*GBITS +: GBITS];
        end
      end
      cfg_update_ack_o <= cfg_update_i;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      for (int k = 0; k < NCH; k++) begin
        s1_dat[k]  <= '0;
        s1_off[k]  <= '0;
        s1_gain[k] <= '0;
        s2_dat[k]  <= '0;
        s2_gain[k] <= '0;
        s3_prod[k] <= '0;
      end
      s1_vld              <= 1'b0;
      s2_sat              <= '0;
      s2_vld              <= 1'b0;
      s3_sat              <= '0;
      s3_vld              <= 1'b0;
      calib_dat_o         <= '0;
      calib_dout_tvalid_o <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        s1_dat[k]  <= calib_dat_i[k*DBITS +: DBITS];
        s1_off[k]  <= act_off[k];
        s1_gain[k] <= act_gain[k];
        s2_dat[k]  <= clp2_c[k];
        s2_gain[k] <= s1_gain[k];
        s3_prod[k] <= prod_c[k];
        calib_dat_o[k*DBITS +: DBITS] <= clp4_c[k];
      end
      s1_vld              <= calib_din_tvalid_i;
      s2_sat              <= sat2_c;
      s2_vld              <= s1_vld;
      s3_sat              <= s2_sat;
      s3_vld              <= s2_vld;
      calib_dout_tvalid_o <= s3_vld;
    end
  end

  // sticky flags update on the same edge the saturated sample is output
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i)        sat_flag_o <= '0;
    else if (sat_cnt_clr_i) sat_flag_o <= sat_ev_c;
    else                    sat_flag_o <= sat_flag_o | sat_ev_c;
  end

`ifdef SCOPE_CALIB_SATCNT_EN
  localparam logic [SCW-1:0] CMAX = {SCW{1'b1}};

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sat_cnt_o <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (sat_cnt_clr_i)
          sat_cnt_o[k*SCW +: SCW] <= SCW'(sat_ev_c[k]);
        else if (sat_ev_c[k] && (sat_cnt_o[k*SCW +: SCW] != CMAX))
          sat_cnt_o[k*SCW +: SCW] <= sat_cnt_o[k*SCW +: SCW] + SCW'(1);
      end
    end
  end
`else
  assign sat_cnt_o = '0;
`endif

endmodule
